// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider for the EX stage (DIV / DIVU).
// One quotient bit per clock; result is {remainder, quotient}, held while start_i stays high.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic        neg_quo_r;
  logic        neg_rem_r;
  logic [32:0] shifted;
  logic [32:0] trial;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? neg32(v) : v;
  endfunction

  // Partial remainder stays below the divisor, so the shifted value fits in 33 bits
  // and bit 32 of the difference acts as the borrow.
  always_comb begin
    shifted = {rem_r, quo_r[31]};
    trial   = shifted - {1'b0, dvs_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FREE;
      cnt       <= 6'd0;
      rem_r     <= 32'd0;
      quo_r     <= 32'd0;
      dvs_r     <= 32'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_o  <= 64'd0;
      ready_o   <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            // Magnitudes are latched up front; -2^31 maps to 0x80000000 unsigned.
            quo_r     <= mag32(opdata1_i, signed_div_i);
            dvs_r     <= mag32(opdata2_i, signed_div_i);
            rem_r     <= 32'd0;
            neg_quo_r <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_r <= signed_div_i && opdata1_i[31];
            cnt       <= 6'd0;
            state     <= (opdata2_i == 32'd0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (start_i && !annul_i) begin
            state    <= END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end else begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        ON: begin
          if (!start_i || annul_i) begin
            state    <= FREE;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt != 6'd32) begin
            if (!trial[32]) begin
              rem_r <= trial[31:0];
              quo_r <= {quo_r[30:0], 1'b1};
            end else begin
              rem_r <= shifted[31:0];
              quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {apply_sign(rem_r, neg_rem_r), apply_sign(quo_r, neg_quo_r)};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= FREE;
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; all data widths are fixed at 32 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (asserted at 0).
REQ-004 The block SHALL have port signed_div_i, input, 1 bit: 1 = signed division (DIV), 0 = unsigned (DIVU).
REQ-005 The block SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-006 The block SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-007 The block SHALL have port start_i, input, 1 bit: request from the EX stage; held high until the result is consumed.
REQ-008 The block SHALL have port annul_i, input, 1 bit: abort the operation in progress.
REQ-009 The block SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}. EX routes these to ex_hi / ex_lo with ex_whilo=1.
REQ-010 The block SHALL have port ready_o, output, 1 bit: result_o is valid.

Function
REQ-011 The block SHALL implement a four-state FSM with states FREE, BYZERO, ON and END.
REQ-012 FREE: on an edge with start_i=1 and annul_i=0, the block SHALL latch opdata1_i, opdata2_i and signed_div_i. It SHALL go to BYZERO if opdata2_i==0, otherwise to ON with the 6-bit iteration counter cleared.
REQ-013 ON: the block SHALL perform one restoring shift-subtract iteration per edge while counter<32, then increment the counter. On the edge with counter==32 it SHALL register the result, set ready_o=1 and go to END.
REQ-014 Latency: with start sampled at edge E0, the ON path SHALL assert ready_o after edge E0+33. The BYZERO path SHALL go to END at edge E0+1 with result_o=0 and ready_o=1.
REQ-015 Signed mode: the block SHALL divide the magnitudes (two's-complement negation of negative operands). The quotient SHALL be negated when the operand signs differ. The remainder SHALL take the sign of the dividend.
REQ-016 Overflow case -2^31 / -1 (signed) SHALL yield quotient 0x80000000 and remainder 0, with no exception.
REQ-017 An edge in ON or BYZERO with annul_i=1 or start_i=0 SHALL return the FSM to FREE, with ready_o=0 and result_o=0.
REQ-018 END: ready_o and result_o SHALL hold while start_i=1. On the first edge with start_i=0 the FSM SHALL go to FREE and clear ready_o and result_o.
REQ-019 A new operation SHALL NOT be accepted in END. Back-to-back divides therefore need at least one FREE cycle.
REQ-020 Changes on opdata1_i, opdata2_i or signed_div_i after the start edge SHALL NOT affect the operation in progress.
REQ-021 result_o and ready_o SHALL be registered outputs.
REQ-022 result_o SHALL be 0 in every state other than END.

Reset
REQ-023 While rst=0, regardless of clock: FSM SHALL be FREE, counter 0, ready_o=0, result_o=0, latched operands 0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation. After release, the block SHALL wait in FREE for a fresh start_i.
REQ-025 The first rising clk edge after rst rises SHALL evaluate the FREE state normally.

Verification
REQ-026 Unsigned 100/7: start at E0 -> ready_o=1 after E0+33; result_o=0x00000002_0000000E. ready_o=0 before that edge.
REQ-027 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. The same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-028 Divide by zero 5/0 -> ready_o=1 after E0+1, result_o=0. Dropping start_i -> FREE, ready_o=0.
REQ-029 annul_i=1 at E0+10 -> FSM FREE, ready_o stays 0. A new start_i on the next cycle completes correctly with the new operands.
REQ-030 rst pulsed low at E0+20 of a signed divide -> outputs 0 immediately (asynchronous). No ready_o until a new start_i is given.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. start_i held high for 5 cycles after ready_o -> outputs stable. The cycle after start_i falls -> ready_o=0, result_o=0.
